led_decoder: RTL and testbench
==============================

LED_DECODER -- requirements
Module: led_decoder

Interface
REQ-001 Parameter: ACTIVE_LOW, default 0, segment polarity; 0 = segment lit when its bit is 1, 1 = all output bits inverted for common-anode displays.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: char  input  4  character code to display.
REQ-005 Port: LED  output  7  registered seven-segment drive, LED[6:0] = {a,b,c,d,e,f,g}.

Function
REQ-006 LED SHALL be driven only from a register updated on rising clk; no combinational path from char to LED.
REQ-007 Latency SHALL be exactly one clock: LED after edge N reflects char sampled at edge N.
REQ-008 Lit-segment patterns (a..g, 1 = lit) SHALL be:
  - 0 -> 1111110
  - 1 -> 0110000
  - 2 -> 1101101
  - 3 -> 1111001
  - 4 -> 0110011
  - 5 -> 1011011
  - 6 -> 1011111
  - 7 -> 1110000
  - 8 -> 1111111
  - 9 -> 1111011
  - 10 (dash '-') -> 0000001
  - 11 ('F') -> 1000111
  - 12 (space) -> 0000000
REQ-009 Codes 13, 14, 15 SHALL display blank (0000000 lit pattern), same as space.
REQ-010 With ACTIVE_LOW=1, LED SHALL be the bitwise inverse of the REQ-008/009 lit pattern; with ACTIVE_LOW=0, LED SHALL equal it.
REQ-011 An X/Z on char SHALL NOT be required to produce any specific value; all 16 defined codes SHALL be fully decoded (no latch, no default-to-X).
REQ-012 char changing every cycle SHALL be tracked every cycle; no hold or debounce.
REQ-013 LED SHALL hold its value while char is stable.

Reset
REQ-014 While reset=1 at a rising edge, LED SHALL load the blank pattern (0000000 for ACTIVE_LOW=0, 1111111 for ACTIVE_LOW=1), regardless of char.
REQ-015 Reset SHALL take priority over decode when both apply at the same edge.
REQ-016 First edge with reset=0 SHALL load the decode of char sampled at that edge.
REQ-017 Reset asserted mid-stream SHALL blank LED at the next edge; no other internal state exists to clear.
REQ-018 Before the first reset edge LED is undefined; benches SHALL apply reset for at least one edge.

Verification
REQ-019 reset=1 for 5 edges with char=8 -> LED=0000000 each cycle; release reset, char=8 -> LED=1111111 after one edge.
REQ-020 Sweep char 0,1,2,3,4,5,6,12,11,10,9,8,7, one code per edge -> LED follows REQ-008 table, one cycle delayed (e.g. char=11 -> 1000111, char=10 -> 0000001).
REQ-021 char=13,14,15 -> LED=0000000 after one edge each.
REQ-022 ACTIVE_LOW=1 instance: reset -> 1111111; char=0 -> 0000001; char=1 -> 1001111.
REQ-023 Stream char=5 then assert reset with char=5 -> LED=1011011 then 0000000; deassert -> 1011011 next edge.
REQ-024 Change char between edges -> LED unchanged until next rising clk.

Source files
------------

// File: rtl/led_decoder.sv
// led_decoder: registered 4-bit character to seven-segment decoder, LED = {a,b,c,d,e,f,g}.
// ACTIVE_LOW inverts every output bit for common-anode displays; reset loads the blank pattern.
module led_decoder #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] char,
    output logic [6:0] LED
);
    logic [6:0] lit;
    always_comb begin
        lit = 7'b0000000;
        case (char)
            4'd0:    lit = 7'b1111110;
            4'd1:    lit = 7'b0110000;
            4'd2:    lit = 7'b1101101;
            4'd3:    lit = 7'b1111001;
            4'd4:    lit = 7'b0110011;
            4'd5:    lit = 7'b1011011;
            4'd6:    lit = 7'b1011111;
            4'd7:    lit = 7'b1110000;
            4'd8:    lit = 7'b1111111;
            4'd9:    lit = 7'b1111011;
            4'd10:   lit = 7'b0000001;
            4'd11:   lit = 7'b1000111;
            default: lit = 7'b0000000;
        endcase
    end
    always_ff @(posedge clk)
        LED <= reset ? {7{ACTIVE_LOW}} : (ACTIVE_LOW ? ~lit : lit);
endmodule

// File: tb/tb_led_decoder.sv
// tb_led_decoder: scoreboard bench driving an active-high and an active-low decoder in lockstep.
module tb_led_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] char = 4'd0;
    logic [6:0] led_hi, led_lo;
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic [6:0] e_hi;
        logic [6:0] e_lo;
        string      name;
    } exp_t;
    exp_t q[$];
    logic [6:0] pat [16];
    always #5 clk = ~clk;
    led_decoder #(.ACTIVE_LOW(1'b0)) u_hi (.clk(clk), .reset(reset), .char(char), .LED(led_hi));
    led_decoder #(.ACTIVE_LOW(1'b1)) u_lo (.clk(clk), .reset(reset), .char(char), .LED(led_lo));
    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask
    task automatic step(input logic r, input logic [3:0] c, input logic [6:0] e_hi, input logic [6:0] e_lo, input string name);
        exp_t e;
        @(negedge clk);
        reset = r;
        char = c;
        e.e_hi = e_hi;
        e.e_lo = e_lo;
        e.name = name;
        q.push_back(e);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check({e.name, "_hi"}, led_hi, e.e_hi);
                check({e.name, "_lo"}, led_lo, e.e_lo);
            end
        end
    end
    initial begin
        int seq [13] = '{0, 1, 2, 3, 4, 5, 6, 12, 11, 10, 9, 8, 7};
        int budget;
        pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
        pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b1011111; pat[7] = 7'b1110000;
        pat[8] = 7'b1111111; pat[9] = 7'b1111011; pat[10] = 7'b0000001; pat[11] = 7'b1000111;
        pat[12] = 7'b0000000; pat[13] = 7'b0000000; pat[14] = 7'b0000000; pat[15] = 7'b0000000;
        for (int i = 0; i < 5; i++) step(1'b1, 4'd8, 7'b0000000, 7'b1111111, "reset_char8");
        step(1'b0, 4'd8, 7'b1111111, 7'b0000000, "release_char8");
        for (int i = 0; i < 13; i++)
            step(1'b0, 4'(seq[i]), pat[seq[i]], ~pat[seq[i]], $sformatf("sweep_%0d", seq[i]));
        for (int i = 13; i < 16; i++)
            step(1'b0, 4'(i), 7'b0000000, 7'b1111111, $sformatf("blank_%0d", i));
        step(1'b1, 4'd0, 7'b0000000, 7'b1111111, "reset_lo");
        step(1'b0, 4'd0, 7'b1111110, 7'b0000001, "al_char0");
        step(1'b0, 4'd1, 7'b0110000, 7'b1001111, "al_char1");
        step(1'b0, 4'd5, 7'b1011011, 7'b0100100, "stream5");
        step(1'b0, 4'd5, 7'b1011011, 7'b0100100, "hold5");
        step(1'b1, 4'd5, 7'b0000000, 7'b1111111, "midreset5");
        step(1'b0, 4'd5, 7'b1011011, 7'b0100100, "rerelease5");
        for (int i = 0; i < 6; i++)
            step(1'b0, 4'(2 * i + 1), pat[2 * i + 1], ~pat[2 * i + 1], $sformatf("fast_%0d", 2 * i + 1));
        @(posedge clk);
        #2;
        char = 4'd8;
        #2;
        check("between_edges_hi", led_hi, pat[11]);
        check("between_edges_lo", led_lo, ~pat[11]);
        step(1'b0, 4'd8, 7'b1111111, 7'b0000000, "after_edge8");
        budget = 0;
        while (q.size() != 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
